// File: rtl/gate_selftest_ctrl.sv
// gate_selftest_ctrl: self-test sequencer for a 2-input combinational gate.
// It steps {b,a} through 00,01,10,11 and holds each vector for STEP_CYCLES
// clocks. At the end of each hold it samples gate_y against the EXPECT truth
// table. It then reports pass, the mismatch count and the first failing vector.
module gate_selftest_ctrl #(
    parameter int         STEP_CYCLES = 10,
    parameter logic [3:0] EXPECT      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] first_fail
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       rst_sync_reg;
    logic             rst_int_n;
    logic [1:0]       state_reg;
    logic [1:0]       idx_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             miss;
    logic [1:0]       idx_next;

    // Reset synchronizer: the reset asserts immediately and is released only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_reg[1];
    assign miss      = (gate_y != EXPECT[idx_reg]);
    assign idx_next  = idx_reg + 2'd1;

    // Sequencer: IDLE waits for start, HOLD walks the four vectors, FINISH pulses done.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_reg  <= S_IDLE;
            idx_reg    <= 2'd0;
            cnt_reg    <= '0;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            first_fail <= 2'd0;
        end else if (abort) begin
            // Abort wins over everything, including a simultaneous start.
            state_reg  <= S_IDLE;
            idx_reg    <= 2'd0;
            cnt_reg    <= '0;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            first_fail <= 2'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_reg  <= S_HOLD;
                        idx_reg    <= 2'd0;
                        cnt_reg    <= '0;
                        gate_a     <= 1'b0;
                        gate_b     <= 1'b0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= 3'd0;
                        first_fail <= 2'd0;
                    end
                end
                S_HOLD: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        if (miss) begin
                            err_count <= err_count + 3'd1;
                            if (err_count == 3'd0) begin
                                first_fail <= idx_reg;
                            end
                        end
                        if (idx_reg == 2'd3) begin
                            // The final sample is folded into pass on the way out.
                            state_reg <= S_FINISH;
                            gate_a    <= 1'b0;
                            gate_b    <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_count == 3'd0) && !miss;
                        end else begin
                            idx_reg <= idx_next;
                            gate_a  <= idx_next[0];
                            gate_b  <= idx_next[1];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                S_FINISH: begin
                    state_reg <= S_IDLE;
                    idx_reg   <= 2'd0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    idx_reg   <= 2'd0;
                    cnt_reg   <= '0;
                    gate_a    <= 1'b0;
                    gate_b    <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Testbench for gate_selftest_ctrl: two instances (STEP_CYCLES=10 with AND
// table, STEP_CYCLES=1 with XOR table) driven by a truth-table gate model,
// checked against expected results derived from the truth tables.
module tb_gate_selftest_ctrl;

    localparam logic [3:0] EXP0 = 4'b1000;
    localparam logic [3:0] EXP1 = 4'b0110;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start_s;
    logic [1:0] abort_s;
    logic [1:0] ga;
    logic [1:0] gb;
    logic [1:0] gy;
    logic [1:0] busy_s;
    logic [1:0] done_s;
    logic [1:0] pass_s;
    logic [2:0] err0;
    logic [2:0] err1;
    logic [1:0] ff0;
    logic [1:0] ff1;
    logic [3:0] tt0;
    logic [3:0] tt1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Gate models: each output is the truth table looked up by {b,a}.
    assign gy[0] = tt0[{gb[0], ga[0]}];
    assign gy[1] = tt1[{gb[1], ga[1]}];

    gate_selftest_ctrl #(.STEP_CYCLES(10), .EXPECT(EXP0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .gate_a(ga[0]), .gate_b(gb[0]), .gate_y(gy[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .err_count(err0), .first_fail(ff0)
    );

    gate_selftest_ctrl #(.STEP_CYCLES(1), .EXPECT(EXP1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .gate_a(ga[1]), .gate_b(gb[1]), .gate_y(gy[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .err_count(err1), .first_fail(ff1)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] err_of(input int u);
        return (u == 0) ? err0 : err1;
    endfunction

    function automatic logic [1:0] ff_of(input int u);
        return (u == 0) ? ff0 : ff1;
    endfunction

    // All outputs of one unit packed into a single word.
    function automatic logic [15:0] outs_of(input int u);
        return 16'({ga[u], gb[u], busy_s[u], done_s[u], pass_s[u], err_of(u), ff_of(u)});
    endfunction

    // One self-test run on unit u with gate truth table tt.
    task automatic run(input int u, input logic [3:0] tt, input int abort_at, input bit repulse);
        int         s;
        logic [3:0] expv;
        int         errs;
        int         ffe;
        bit         seen;
        s    = (u == 0) ? 10 : 1;
        expv = (u == 0) ? EXP0 : EXP1;
        errs = 0;
        ffe  = 0;
        for (int i = 0; i < 4; i++) begin
            if (tt[i] != expv[i]) begin
                if (errs == 0) ffe = i;
                errs++;
            end
        end
        if (u == 0) tt0 = tt; else tt1 = tt;
        start_s[u] = 1'b1;
        @(posedge clk); #1;
        start_s[u] = 1'b0;
        for (int k = 0; k < 4 * s; k++) begin
            check_val("busy_hold", 16'(busy_s[u]), 16'd1);
            check_val("done_early", 16'(done_s[u]), 16'd0);
            check_val("vector", 16'({gb[u], ga[u]}), 16'(k / s));
            if (repulse && k == 1) start_s[u] = 1'b1;
            if (repulse && k == 2) start_s[u] = 1'b0;
            if (k == abort_at) begin
                abort_s[u] = 1'b1;
                @(posedge clk); #1;
                abort_s[u] = 1'b0;
                start_s[u] = 1'b0;
                check_val("abort_outs", outs_of(u), 16'd0);
                seen = 1'b0;
                repeat (4 * s + 2) begin
                    @(posedge clk); #1;
                    if (done_s[u] !== 1'b0) seen = 1'b1;
                end
                check_val("abort_nodone", 16'(seen), 16'd0);
                $display("run u=%0d tt=%b aborted at %0d", u, tt, k);
                return;
            end
            @(posedge clk); #1;
        end
        start_s[u] = 1'b0;
        check_val("done_pulse", 16'(done_s[u]), 16'd1);
        check_val("busy_finish", 16'(busy_s[u]), 16'd1);
        check_val("gates_finish", 16'({gb[u], ga[u]}), 16'd0);
        check_val("pass", 16'(pass_s[u]), 16'(errs == 0));
        check_val("err_count", 16'(err_of(u)), 16'(errs));
        check_val("first_fail", 16'(ff_of(u)), 16'(ffe));
        @(posedge clk); #1;
        check_val("done_single", 16'(done_s[u]), 16'd0);
        check_val("busy_idle", 16'(busy_s[u]), 16'd0);
        check_val("results_held", 16'({pass_s[u], err_of(u), ff_of(u)}),
                  16'({(errs == 0), 3'(errs), 2'(ffe)}));
        repeat (3) @(posedge clk);
        #1;
        check_val("no_rerun", 16'({busy_s[u], done_s[u]}), 16'd0);
        $display("run u=%0d tt=%b err=%0d ff=%0d pass=%0b", u, tt, err_of(u), ff_of(u), pass_s[u]);
    endtask

    initial begin
        int ab;
        rst_n   = 1'b0;
        start_s = 2'b00;
        abort_s = 2'b00;
        tt0     = 4'b1000;
        tt1     = 4'b0110;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_u0", outs_of(0), 16'd0);
        check_val("reset_u1", outs_of(1), 16'd0);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Directed: good AND, stuck-at-0, OR gate, abort mid-run.
        run(0, 4'b1000, -1, 1'b0);
        run(0, 4'b0000, -1, 1'b0);
        // Abort together with start in IDLE: stays idle and clears results.
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        check_val("abort_start_idle", outs_of(0), 16'd0);
        run(0, 4'b1110, -1, 1'b0);
        run(0, 4'b1000, 15, 1'b0);

        // Asynchronous reset in the middle of a hold.
        tt0 = 4'b1000;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("async_reset", outs_of(0), 16'd0);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run(0, 4'b1000, -1, 1'b0);

        // Single-cycle steps with a start re-pulsed while busy.
        run(1, 4'b0110, -1, 1'b1);

        // Randomized runs on both units.
        for (int r = 0; r < 10; r++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 39)) : -1;
            run(0, 4'($urandom_range(0, 15)), ab, 1'b0);
        end
        for (int r = 0; r < 16; r++) begin
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            run(1, 4'($urandom_range(0, 15)), ab, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
